// File: rtl/rfsched_pkg.sv
// rfsched_pkg: shared definitions for the register file read-port scheduler.
// Contents: lane count, lane index constants, scheduler state type.
package rfsched_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned PIDX_W    = 2;  // port index width (NUM_PORTS <= 4)

  localparam int unsigned S0_RS = 0;
  localparam int unsigned S0_RT = 1;
  localparam int unsigned S1_RS = 2;
  localparam int unsigned S1_RT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/rfsched_pick.sv
// rfsched_pick: combinational read-port picker.
// Scans pending lanes 0..3 in order and hands out up to NUM_PORTS read ports,
// lowest port first.
// Optional feature macro: RFSCHED_COALESCE_EN -- a lane whose address matches a
// lower lane already granted this cycle shares that lane's port for free.
// Ports:
//   pending    in   per-lane outstanding read
//   lane_addr  in   lane i address at [i*ADDR_W +: ADDR_W]
//   port_en    out  port k in use
//   port_addr  out  port k address (0 when unused)
//   lane_grant out  lane i served this cycle
//   lane_port  out  lane i port index at [i*PIDX_W +: PIDX_W]
module rfsched_pick
  import rfsched_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic [NUM_LANES-1:0]        pending,
  input  logic [NUM_LANES*ADDR_W-1:0] lane_addr,
  output logic [NUM_PORTS-1:0]        port_en,
  output logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  output logic [NUM_LANES-1:0]        lane_grant,
  output logic [NUM_LANES*PIDX_W-1:0] lane_port
);

  always_comb begin
    int unsigned used;
    logic        hit;
    port_en    = '0;
    port_addr  = '0;
    lane_grant = '0;
    lane_port  = '0;
    used       = 0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      hit = 1'b0;
`ifdef RFSCHED_COALESCE_EN
      // Share the port of the first lower lane granted with the same address.
      for (int unsigned j = 0; j < i; j++) begin
        if (!hit && pending[i] && lane_grant[j] &&
            lane_addr[j*ADDR_W +: ADDR_W] == lane_addr[i*ADDR_W +: ADDR_W]) begin
          hit                          = 1'b1;
          lane_grant[i]                = 1'b1;
          lane_port[i*PIDX_W +: PIDX_W] = lane_port[j*PIDX_W +: PIDX_W];
        end
      end
`endif
      if (pending[i] && !hit && used < NUM_PORTS) begin
        lane_grant[i]                      = 1'b1;
        lane_port[i*PIDX_W +: PIDX_W]      = used[PIDX_W-1:0];
        port_en[used]                      = 1'b1;
        port_addr[used*ADDR_W +: ADDR_W]   = lane_addr[i*ADDR_W +: ADDR_W];
        used                               = used + 1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_sched.sv
// regfile_read_sched: sequences one issue bundle of up to four source operands
// over NUM_PORTS register file read ports and returns the full operand set
// through a valid/ready handshake.
// Optional feature macro: RFSCHED_COALESCE_EN (same-address lanes share a port).
// Ports:
//   clock, reset_n           clock, synchronous active-low reset
//   req_valid/req_ready      bundle handshake (accepted only in IDLE)
//   req_addr, req_need       lane addresses and operand-required mask
//   rd_en, rd_addr, rd_data  register file read ports (data same cycle)
//   opnd_valid/opnd_ready    operand set handshake
//   opnd_data                lane i operand at [i*DATA_W +: DATA_W]
module regfile_read_sched
  import rfsched_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [NUM_LANES*ADDR_W-1:0] req_addr,
  input  logic [NUM_LANES-1:0]        req_need,
  output logic [NUM_PORTS-1:0]        rd_en,
  output logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] rd_data,
  output logic                        opnd_valid,
  input  logic                        opnd_ready,
  output logic [NUM_LANES*DATA_W-1:0] opnd_data
);

  state_t                        state;
  logic [NUM_LANES*ADDR_W-1:0]   lane_addr_q;
  logic [NUM_LANES-1:0]          pending_q;
  logic [NUM_LANES*DATA_W-1:0]   opnd_q;

  logic [NUM_LANES-1:0]          req_pend;
  logic [NUM_LANES-1:0]          pend_left;
  logic [NUM_PORTS-1:0]          port_en;
  logic [NUM_PORTS*ADDR_W-1:0]   port_addr;
  logic [NUM_LANES-1:0]          lane_grant;
  logic [NUM_LANES*PIDX_W-1:0]   lane_port;

  rfsched_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ADDR_W    (ADDR_W)
  ) u_pick (
    .pending    (pending_q),
    .lane_addr  (lane_addr_q),
    .port_en    (port_en),
    .port_addr  (port_addr),
    .lane_grant (lane_grant),
    .lane_port  (lane_port)
  );

  // Register 0 always reads zero, so it never needs a port.
  always_comb begin
    req_pend = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      req_pend[i] = req_need[i] && (req_addr[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  assign pend_left  = pending_q & ~lane_grant;
  assign req_ready  = (state == IDLE);
  assign opnd_valid = (state == HOLD);
  assign opnd_data  = opnd_q;
  assign rd_en      = (state == READ) ? port_en   : '0;
  assign rd_addr    = (state == READ) ? port_addr : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      lane_addr_q <= '0;
      pending_q   <= '0;
      opnd_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane_addr_q <= req_addr;
            pending_q   <= req_pend;
            opnd_q      <= '0;
            state       <= (req_pend == '0) ? HOLD : READ;
          end
        end
        READ: begin
          for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_grant[i]) begin
              opnd_q[i*DATA_W +: DATA_W] <=
                rd_data[lane_port[i*PIDX_W +: PIDX_W]*DATA_W +: DATA_W];
            end
          end
          pending_q <= pend_left;
          if (pend_left == '0) state <= HOLD;
        end
        HOLD: begin
          if (opnd_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_read_sched.sv
// tb_regfile_read_sched: self-checking bench for regfile_read_sched with a
// behavioural register file and an operand/port-usage reference model.
module tb_regfile_read_sched;

  localparam int unsigned NP = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            req_valid;
  logic            req_ready;
  logic [4*AW-1:0] req_addr;
  logic [3:0]      req_need;
  logic [NP-1:0]   rd_en;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic            opnd_valid;
  logic            opnd_ready;
  logic [4*DW-1:0] opnd_data;

  always #5 clock = ~clock;

  regfile_read_sched #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .ADDR_W    (AW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_need   (req_need),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .opnd_valid (opnd_valid),
    .opnd_ready (opnd_ready),
    .opnd_data  (opnd_data)
  );

  logic [DW-1:0] regs [32];

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NP; k++) rd_data[k*DW +: DW] = regs[rd_addr[k*AW +: AW]];
  end

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // reference model results
  int unsigned      exp_cycles;
  logic [NP-1:0]    exp_en   [8];
  logic [NP*AW-1:0] exp_addr [8];
  logic [4*DW-1:0]  exp_data;

  // observations from run_bundle
  int unsigned      obs_cycles;
  logic [NP-1:0]    obs_en   [8];
  logic [NP*AW-1:0] obs_addr [8];
  logic [4*DW-1:0]  obs_data;
  logic             obs_offer_ready;
  logic             obs_idle_ready;
  bit               timed_out;

  task automatic rand_regs();
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
  endtask

  // Distinct reads in lane order; with coalescing, equal addresses collapse
  // into one read. Read j goes to cycle j/NP, port j%NP.
  task automatic model_bundle(input logic [4*AW-1:0] a, input logic [3:0] need);
    logic [AW-1:0] reads [4];
    logic [AW-1:0] ai;
    int unsigned   n;
    bit            found;
    n = 0;
    exp_data = '0;
    for (int i = 0; i < 4; i++) begin
      ai = a[i*AW +: AW];
      if (need[i] && ai != 0) begin
        exp_data[i*DW +: DW] = regs[ai];
        found = 0;
`ifdef RFSCHED_COALESCE_EN
        for (int unsigned g = 0; g < n; g++) if (reads[g] == ai) found = 1;
`endif
        if (!found) begin
          reads[n] = ai;
          n++;
        end
      end
    end
    exp_cycles = (n + NP - 1) / NP;
    for (int unsigned c = 0; c < 8; c++) begin
      exp_en[c] = '0;
      exp_addr[c] = '0;
      for (int unsigned p = 0; p < NP; p++) begin
        if (c*NP + p < n) begin
          exp_en[c][p] = 1'b1;
          exp_addr[c][p*AW +: AW] = reads[c*NP + p];
        end
      end
    end
  endtask

  // Offer one bundle, record every pre-HOLD cycle's port usage, then consume.
  task automatic run_bundle(input logic [4*AW-1:0] a, input logic [3:0] need, input bit early);
    for (int c = 0; c < 8; c++) begin
      obs_en[c] = '0;
      obs_addr[c] = '0;
    end
    @(negedge clock);
    obs_offer_ready = req_ready;
    req_valid = 1'b1;
    req_addr = a;
    req_need = need;
    opnd_ready = early;
    @(negedge clock);
    req_valid = 1'b0;
    obs_cycles = 0;
    timed_out = 0;
    while (!opnd_valid) begin
      if (obs_cycles == 8) begin
        timed_out = 1;
        break;
      end
      obs_en[obs_cycles] = rd_en;
      obs_addr[obs_cycles] = rd_addr;
      obs_cycles++;
      @(negedge clock);
    end
    obs_data = opnd_data;
    opnd_ready = 1'b1;
    @(negedge clock);
    opnd_ready = 1'b0;
    obs_idle_ready = req_ready;
    if (timed_out) begin
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_need = '0;
    opnd_ready = 1'b0;
    rand_regs();
    repeat (2) @(negedge clock);
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b want=1", req_ready); else n_pass++;
    n_total++; if (opnd_valid !== 1'b0) $display("FAIL reset_opnd_valid got=%b want=0", opnd_valid); else n_pass++;
    n_total++; if (rd_en !== '0) $display("FAIL reset_rd_en got=%b want=0", rd_en); else n_pass++;
    n_total++; if (rd_addr !== '0) $display("FAIL reset_rd_addr got=%h want=0", rd_addr); else n_pass++;
    n_total++; if (opnd_data !== '0) $display("FAIL reset_opnd_data got=%h want=0", opnd_data); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_four_distinct();
    logic [4*AW-1:0] a;
    a = {5'd12, 5'd9, 5'd7, 5'd3};
    rand_regs();
    model_bundle(a, 4'b1111);
    run_bundle(a, 4'b1111, 1'b0);
    n_total++; if (timed_out || obs_cycles !== 2) $display("FAIL four_cycles got=%0d want=2", obs_cycles); else n_pass++;
    n_total++; if ({obs_en[0], obs_addr[0]} !== {2'b11, 5'd7, 5'd3}) $display("FAIL four_read1 got=%b/%h want=11/{7,3}", obs_en[0], obs_addr[0]); else n_pass++;
    n_total++; if ({obs_en[1], obs_addr[1]} !== {2'b11, 5'd12, 5'd9}) $display("FAIL four_read2 got=%b/%h want=11/{12,9}", obs_en[1], obs_addr[1]); else n_pass++;
    n_total++; if (obs_data !== exp_data) $display("FAIL four_data got=%h want=%h", obs_data, exp_data); else n_pass++;
    n_total++; if (obs_idle_ready !== 1'b1) $display("FAIL four_idle_ready got=%b want=1", obs_idle_ready); else n_pass++;
  endtask

  task automatic test_zero_addr();
    logic [4*AW-1:0] a;
    a = {5'd0, 5'd5, 5'd0, 5'd0};
    rand_regs();
    model_bundle(a, 4'b1111);
    run_bundle(a, 4'b1111, 1'b0);
    n_total++; if (timed_out || obs_cycles !== 1) $display("FAIL zero_cycles got=%0d want=1", obs_cycles); else n_pass++;
    n_total++; if ({obs_en[0], obs_addr[0]} !== {2'b01, 5'd0, 5'd5}) $display("FAIL zero_read got=%b/%h want=01/{0,5}", obs_en[0], obs_addr[0]); else n_pass++;
    n_total++; if (obs_data !== {32'd0, regs[5], 64'd0}) $display("FAIL zero_data got=%h want=%h", obs_data, {32'd0, regs[5], 64'd0}); else n_pass++;
  endtask

  task automatic test_no_need();
    logic [4*AW-1:0] a;
    a = {5'd1, 5'd2, 5'd3, 5'd4};
    rand_regs();
    run_bundle(a, 4'b0000, 1'b0);
    n_total++; if (timed_out || obs_cycles !== 0) $display("FAIL noneed_cycles got=%0d want=0", obs_cycles); else n_pass++;
    n_total++; if (obs_data !== '0) $display("FAIL noneed_data got=%h want=0", obs_data); else n_pass++;
  endtask

  task automatic test_duplicate();
    logic [4*AW-1:0] a;
    a = {5'd8, 5'd4, 5'd4, 5'd4};
    rand_regs();
    model_bundle(a, 4'b1111);
    run_bundle(a, 4'b1111, 1'b0);
`ifdef RFSCHED_COALESCE_EN
    n_total++; if (timed_out || obs_cycles !== 1) $display("FAIL dup_cycles got=%0d want=1", obs_cycles); else n_pass++;
`else
    n_total++; if (timed_out || obs_cycles !== 2) $display("FAIL dup_cycles got=%0d want=2", obs_cycles); else n_pass++;
`endif
    for (int unsigned c = 0; c < exp_cycles; c++) begin
      n_total++;
      if ({obs_en[c], obs_addr[c]} !== {exp_en[c], exp_addr[c]})
        $display("FAIL dup_read%0d got=%b/%h want=%b/%h", c, obs_en[c], obs_addr[c], exp_en[c], exp_addr[c]);
      else n_pass++;
    end
    n_total++; if (obs_data !== exp_data) $display("FAIL dup_data got=%h want=%h", obs_data, exp_data); else n_pass++;
  endtask

  task automatic test_hold_stall();
    logic [4*AW-1:0] a;
    int unsigned     w;
    a = {5'd31, 5'd17, 5'd2, 5'd6};
    rand_regs();
    model_bundle(a, 4'b1011);
    @(negedge clock);
    req_valid = 1'b1;
    req_addr = a;
    req_need = 4'b1011;
    @(negedge clock);
    req_valid = 1'b0;
    w = 0;
    while (!opnd_valid && w < 8) begin
      w++;
      @(negedge clock);
    end
    n_total++; if (opnd_valid !== 1'b1) $display("FAIL stall_reach_hold got=%b want=1", opnd_valid); else n_pass++;
    req_valid = 1'b1;
    req_addr = {5'd1, 5'd1, 5'd1, 5'd1};
    req_need = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      n_total++; if (opnd_valid !== 1'b1) $display("FAIL stall_valid%0d got=%b want=1", k, opnd_valid); else n_pass++;
      n_total++; if (opnd_data !== exp_data) $display("FAIL stall_data%0d got=%h want=%h", k, opnd_data, exp_data); else n_pass++;
      n_total++; if (req_ready !== 1'b0) $display("FAIL stall_req_ready%0d got=%b want=0", k, req_ready); else n_pass++;
    end
    req_valid = 1'b0;
    opnd_ready = 1'b1;
    @(negedge clock);
    opnd_ready = 1'b0;
    n_total++; if ({req_ready, opnd_valid} !== 2'b10) $display("FAIL stall_release got=%b want=10", {req_ready, opnd_valid}); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    rand_regs();
    @(negedge clock);
    req_valid = 1'b1;
    req_addr = {5'd12, 5'd9, 5'd7, 5'd3};
    req_need = 4'b1111;
    @(negedge clock);
    req_valid = 1'b0;
    n_total++; if (rd_en !== 2'b11) $display("FAIL rst_read1_en got=%b want=11", rd_en); else n_pass++;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b want=1", req_ready); else n_pass++;
    n_total++; if (opnd_valid !== 1'b0) $display("FAIL rst_opnd_valid got=%b want=0", opnd_valid); else n_pass++;
    n_total++; if (rd_en !== '0) $display("FAIL rst_rd_en got=%b want=0", rd_en); else n_pass++;
    n_total++; if (opnd_data !== '0) $display("FAIL rst_opnd_data got=%h want=0", opnd_data); else n_pass++;
  endtask

  task automatic test_random();
    logic [4*AW-1:0] a;
    logic [3:0]      need;
    bit              early;
    for (int it = 0; it < 40; it++) begin
      rand_regs();
      for (int i = 0; i < 4; i++)
        a[i*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 5)) : AW'($urandom_range(0, 31));
      need = 4'($urandom_range(0, 15));
      early = 1'($urandom_range(0, 1));
      model_bundle(a, need);
      run_bundle(a, need, early);
      n_total++;
      if (obs_offer_ready !== 1'b1) $display("FAIL rand%0d_offer_ready got=%b want=1", it, obs_offer_ready);
      else n_pass++;
      n_total++;
      if (timed_out || obs_cycles !== exp_cycles)
        $display("FAIL rand%0d_cycles got=%0d want=%0d", it, obs_cycles, exp_cycles);
      else n_pass++;
      for (int unsigned c = 0; c < exp_cycles; c++) begin
        n_total++;
        if ({obs_en[c], obs_addr[c]} !== {exp_en[c], exp_addr[c]})
          $display("FAIL rand%0d_read%0d got=%b/%h want=%b/%h", it, c, obs_en[c], obs_addr[c], exp_en[c], exp_addr[c]);
        else n_pass++;
      end
      n_total++;
      if (obs_data !== exp_data) $display("FAIL rand%0d_data got=%h want=%h", it, obs_data, exp_data);
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_four_distinct();
    test_zero_addr();
    test_no_need();
    test_duplicate();
    test_hold_stall();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_read_sched.md
# regfile_read_sched

Read-port scheduler for the 2-wide processor's register file. Accepts one issue bundle of up to four source operands (slot0 rs/rt, slot1 rs/rt) and sequences them over the register file's NUM_PORTS 32:1 read muxes across as many cycles as needed. It returns the complete operand set to the issue stage through a valid/ready handshake. It sits between decode/issue and the register file read muxes.

## Interface
- NUM_PORTS, 2, number of register file read ports driven (legal 1..4)
- DATA_W, 32, register width
- ADDR_W, 5, register address width (32 registers)
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  issue bundle offered
- req_ready  out  1  scheduler can accept a bundle
- req_addr  in  4*ADDR_W  lane i address at [i*ADDR_W +: ADDR_W]; lanes 0..3 = s0.rs, s0.rt, s1.rs, s1.rt
- req_need  in  4  lane i operand required
- rd_en  out  NUM_PORTS  port k read active this cycle
- rd_addr  out  NUM_PORTS*ADDR_W  port k address; drives that port's mux select
- rd_data  in  NUM_PORTS*DATA_W  port k data, combinational from rd_addr in the same cycle
- opnd_valid  out  1  operand set complete
- opnd_ready  in  1  issue stage consumes the operand set
- opnd_data  out  4*DATA_W  lane i operand; lanes not needed read 0

## Operation
- FSM states: IDLE, READ, HOLD.
- IDLE: req_ready=1. On req_valid:
  - latch req_addr into the lane registers;
  - set pending = req_need & (addr != 0);
  - clear all opnd_data lanes to 0, so register 0 and unneeded lanes read 0 with no port use.
  - If pending is 0, go to HOLD; otherwise go to READ.
- READ: each cycle a picker scans pending lanes in order 0→3 and assigns up to NUM_PORTS ports, lowest port first.
  - Unassigned ports: rd_en=0, rd_addr=0.
  - At the edge, each assigned lane captures its port's rd_data, and its pending bit clears.
  - When pending becomes 0, go to HOLD.
- HOLD: opnd_valid=1, with opnd_data stable. When opnd_ready=1, go to IDLE.
- req_ready is 0 in READ and HOLD. A bundle offered then is not accepted; the requester holds it.
- rd_en and rd_addr are driven only in READ.
- Reset (reset_n=0 at an edge) in any state:
  - state goes to IDLE; pending and lane addresses clear; opnd_data clears to 0.
  - Any in-flight bundle is discarded.
- Outputs at reset: req_ready=1, opnd_valid=0, rd_en=0, rd_addr=0, opnd_data=0.

## Timing
- Accept edge → first READ cycle: 1 cycle.
- READ cycles = ceil(P/NUM_PORTS), where P is the number of distinct reads after coalescing (P ≤ 4).
  - NUM_PORTS=2, four distinct nonzero addresses: 2 READ cycles.
  - opnd_valid rises on the 3rd edge after the accept edge.
- P=0: opnd_valid rises 1 edge after the accept edge.
- HOLD → IDLE takes 1 edge after opnd_ready. The next bundle can be accepted on the following edge, so a new bundle needs at least 1 idle cycle between operand sets.
- opnd_ready asserted before opnd_valid has no effect.

## Configuration
- Macro: RFSCHED_COALESCE_EN.
- Defined:
  - A lane whose address equals that of a lower-numbered lane already assigned in the same cycle shares that lower lane's port.
  - Both lanes capture the same rd_data and clear in the same cycle.
  - Such a lane is not counted against NUM_PORTS.
- Undefined: every pending lane consumes its own port, even when addresses match.

## Structure
- Package rfsched_pkg holds:
  - the lane count constant (4);
  - the state enum {IDLE, READ, HOLD};
  - the lane index constants (S0_RS, S0_RT, S1_RS, S1_RT).
- Sub-module rfsched_pick: combinational. Inputs are the pending mask, lane addresses and NUM_PORTS. Outputs are per-port enable/address and a per-lane grant with its port index. Coalescing logic sits inside, under the macro.

## Test plan
- Reset, then one bundle, NUM_PORTS=2, need=1111, addrs 3,7,9,12:
  - READ 1 reads 3,7; READ 2 reads 9,12;
  - opnd_valid on the 3rd edge after accept;
  - opnd_data equals the register contents.
- Bundle need=1111 with addrs 0,0,5,0: one READ cycle, rd_en=01, rd_addr port0=5; lanes 0,1,3 = 0.
- Bundle need=0000: no READ cycle, HOLD after 1 edge, opnd_data all 0.
- Addrs 4,4,4,8, need=1111:
  - with RFSCHED_COALESCE_EN, one READ cycle covering addresses 4 and 8;
  - without it, 2 READ cycles.
- opnd_ready held 0 for 5 cycles in HOLD: opnd_valid and opnd_data stable, and req_ready=0 with req_valid=1 pending.
- reset_n=0 during READ 1: next cycle IDLE, req_ready=1, opnd_valid=0, rd_en=0, opnd_data=0.
